// File: rtl/and_gate_vector_sequencer_if.sv
// Handshake and status bundle between the AND-gate vector sequencer and its environment.
// master = sequencer side, slave = the gate/controller side.
interface and_gate_vector_sequencer_if #(
   parameter int ERR_W = 4
);
   logic             start;
   logic             gate_out;
   logic             a;
   logic             b;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_count;
   logic             fail_seen;
   logic [1:0]       first_fail;

   modport master (
      input  start, gate_out,
      output a, b, busy, done, pass, err_count, fail_seen, first_fail
   );

   modport slave (
      output start, gate_out,
      input  a, b, busy, done, pass, err_count, fail_seen, first_fail
   );
endinterface

// File: rtl/and_gate_vector_sequencer.sv
// Clocked self-test for a 2-input AND gate: sweeps a/b through 00,01,11,10,
// samples the gate at the end of each hold window and tallies mismatches.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | out of reset, waiting for start; results all zero
// S_RUN  | sweeping vectors; busy=1
// S_DONE | sweep finished; results held until the next start
module and_gate_vector_sequencer #(
   parameter int HOLD_CYCLES = 10,
   parameter int PASSES      = 1,
   parameter int ERR_W       = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   and_gate_vector_sequencer_if.master  bus
);

   localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int PCW = (PASSES > 1) ? $clog2(PASSES) : 1;
   localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);
   localparam logic [PCW-1:0] PASS_LAST = PCW'(PASSES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q,      state_d;
   logic [HCW-1:0]   hold_cnt_q,   hold_cnt_d;
   logic [1:0]       vec_idx_q,    vec_idx_d;
   logic [PCW-1:0]   pass_cnt_q,   pass_cnt_d;
   logic             a_q,          a_d;
   logic             b_q,          b_d;
   logic             busy_q,       busy_d;
   logic             done_q,       done_d;
   logic [ERR_W-1:0] err_count_q,  err_count_d;
   logic             fail_seen_q,  fail_seen_d;
   logic [1:0]       first_fail_q, first_fail_d;

   logic hold_tc;
   logic mismatch;

   assign hold_tc  = (hold_cnt_q == HOLD_LAST);
   assign mismatch = (bus.gate_out != (a_q & b_q));

   always_comb begin
      state_d      = state_q;
      hold_cnt_d   = hold_cnt_q;
      vec_idx_d    = vec_idx_q;
      pass_cnt_d   = pass_cnt_q;
      busy_d       = busy_q;
      done_d       = done_q;
      err_count_d  = err_count_q;
      fail_seen_d  = fail_seen_q;
      first_fail_d = first_fail_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d      = S_RUN;
               hold_cnt_d   = '0;
               vec_idx_d    = 2'd0;
               pass_cnt_d   = '0;
               busy_d       = 1'b1;
               done_d       = 1'b0;
               err_count_d  = '0;
               fail_seen_d  = 1'b0;
               first_fail_d = 2'b00;
            end
         end
         S_RUN: begin
            if (hold_tc) begin
               hold_cnt_d = '0;
               if (mismatch) begin
                  if (err_count_q != {ERR_W{1'b1}})
                     err_count_d = err_count_q + ERR_W'(1);
                  if (!fail_seen_q) begin
                     fail_seen_d  = 1'b1;
                     first_fail_d = {a_q, b_q};
                  end
               end
               vec_idx_d = vec_idx_q + 2'd1;
               if (vec_idx_q == 2'd3) begin
                  if (pass_cnt_q == PASS_LAST) begin
                     state_d    = S_DONE;
                     busy_d     = 1'b0;
                     done_d     = 1'b1;
                     pass_cnt_d = '0;
                  end else begin
                     pass_cnt_d = pass_cnt_q + PCW'(1);
                  end
               end
            end else begin
               hold_cnt_d = hold_cnt_q + HCW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Vector index is a Gray sequence: 0->00, 1->01, 2->11, 3->10.
      a_d = vec_idx_d[1];
      b_d = vec_idx_d[1] ^ vec_idx_d[0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         hold_cnt_q   <= '0;
         vec_idx_q    <= 2'd0;
         pass_cnt_q   <= '0;
         a_q          <= 1'b0;
         b_q          <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_count_q  <= '0;
         fail_seen_q  <= 1'b0;
         first_fail_q <= 2'b00;
      end else begin
         state_q      <= state_d;
         hold_cnt_q   <= hold_cnt_d;
         vec_idx_q    <= vec_idx_d;
         pass_cnt_q   <= pass_cnt_d;
         a_q          <= a_d;
         b_q          <= b_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_count_q  <= err_count_d;
         fail_seen_q  <= fail_seen_d;
         first_fail_q <= first_fail_d;
      end
   end

   assign bus.a          = a_q;
   assign bus.b          = b_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.pass       = done_q && (err_count_q == '0);
   assign bus.err_count  = err_count_q;
   assign bus.fail_seen  = fail_seen_q;
   assign bus.first_fail = first_fail_q;

endmodule

// File: tb/tb_and_gate_vector_sequencer.sv
// Bench for the AND-gate vector sequencer: a one-pass and an eight-pass instance,
// each wrapped around a faultable gate model (AND xor a per-vector flip mask).
module tb_and_gate_vector_sequencer;

   localparam int HOLD  = 10;
   localparam int ERR_W = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       start1, start8;
   logic [3:0] flip1, flip8;
   logic       sel;

   int total = 0;
   int bad   = 0;

   logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

   and_gate_vector_sequencer_if #(.ERR_W(ERR_W)) bus1 ();
   and_gate_vector_sequencer_if #(.ERR_W(ERR_W)) bus8 ();

   and_gate_vector_sequencer #(.HOLD_CYCLES(HOLD), .PASSES(1), .ERR_W(ERR_W)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1.master)
   );

   and_gate_vector_sequencer #(.HOLD_CYCLES(HOLD), .PASSES(8), .ERR_W(ERR_W)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8.master)
   );

   always #5 clk = ~clk;

   // flip[{a,b}]=1 makes the gate answer wrongly for that input pair
   assign bus1.start    = start1;
   assign bus8.start    = start8;
   assign bus1.gate_out = (bus1.a & bus1.b) ^ flip1[{bus1.a, bus1.b}];
   assign bus8.gate_out = (bus8.a & bus8.b) ^ flip8[{bus8.a, bus8.b}];

   logic             o_a, o_b, o_busy, o_done, o_pass, o_fs;
   logic [ERR_W-1:0] o_err;
   logic [1:0]       o_ff;
   assign o_a    = sel ? bus8.a          : bus1.a;
   assign o_b    = sel ? bus8.b          : bus1.b;
   assign o_busy = sel ? bus8.busy       : bus1.busy;
   assign o_done = sel ? bus8.done       : bus1.done;
   assign o_pass = sel ? bus8.pass       : bus1.pass;
   assign o_fs   = sel ? bus8.fail_seen  : bus1.fail_seen;
   assign o_err  = sel ? bus8.err_count  : bus1.err_count;
   assign o_ff   = sel ? bus8.first_fail : bus1.first_fail;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: walk every compare of the run in order, count raw mismatches, clip.
   task automatic model(input logic [3:0] flip, input int passes,
                        output int err, output logic fs, output logic [1:0] ff);
      int raw;
      int emax;
      raw  = 0;
      fs   = 1'b0;
      ff   = 2'b00;
      emax = (1 << ERR_W) - 1;
      for (int p = 0; p < passes; p++)
         for (int v = 0; v < 4; v++)
            if (flip[seq[v]]) begin
               raw++;
               if (!fs) begin
                  fs = 1'b1;
                  ff = seq[v];
               end
            end
      err = (raw > emax) ? emax : raw;
   endtask

   task automatic run_seq(input logic use8, input logic [3:0] flip,
                          input logic hold_start, input string tag);
      int         passes;
      int         cycles;
      int         err_exp;
      logic       fs_exp;
      logic [1:0] ff_exp;
      passes = use8 ? 8 : 1;
      model(flip, passes, err_exp, fs_exp, ff_exp);
      sel = use8;
      if (use8) flip8 = flip; else flip1 = flip;
      @(negedge clk);
      if (use8) start8 = 1'b1; else start1 = 1'b1;
      @(posedge clk);
      #1;
      if (!hold_start) begin
         start1 = 1'b0;
         start8 = 1'b0;
      end
      check({tag, ":start_busy"}, 32'(o_busy), 32'd1);
      check({tag, ":start_done"}, 32'(o_done), 32'd0);
      check({tag, ":start_err"},  32'(o_err),  32'd0);
      check({tag, ":start_fs"},   32'(o_fs),   32'd0);
      check({tag, ":start_ff"},   32'(o_ff),   32'd0);
      cycles = 0;
      while (o_busy === 1'b1 && cycles < 4000) begin
         check({tag, ":ab"}, 32'({o_a, o_b}), 32'(seq[(cycles / HOLD) % 4]));
         @(posedge clk);
         #1;
         cycles++;
      end
      start1 = 1'b0;
      start8 = 1'b0;
      check({tag, ":run_len"}, 32'(cycles), 32'(4 * passes * HOLD));
      check({tag, ":done"},    32'(o_done), 32'd1);
      check({tag, ":ab_end"},  32'({o_a, o_b}), 32'd0);
      check({tag, ":err"},     32'(o_err),  32'(err_exp));
      check({tag, ":fs"},      32'(o_fs),   32'(fs_exp));
      if (fs_exp) check({tag, ":ff"}, 32'(o_ff), 32'(ff_exp));
      check({tag, ":pass"},    32'(o_pass), 32'(err_exp == 0));
      repeat (3) @(posedge clk);
      #1;
      check({tag, ":hold_done"}, 32'(o_done), 32'd1);
      check({tag, ":hold_busy"}, 32'(o_busy), 32'd0);
      check({tag, ":hold_err"},  32'(o_err),  32'(err_exp));
   endtask

   initial begin
      rst    = 1'b1;
      start1 = 1'b0;
      start8 = 1'b0;
      flip1  = 4'h0;
      flip8  = 4'h0;
      sel    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         check("rst:ab",   32'({o_a, o_b}), 32'd0);
         check("rst:busy", 32'(o_busy), 32'd0);
         check("rst:done", 32'(o_done), 32'd0);
         check("rst:pass", 32'(o_pass), 32'd0);
         check("rst:err",  32'(o_err),  32'd0);
         check("rst:fs",   32'(o_fs),   32'd0);
         check("rst:ff",   32'(o_ff),   32'd0);
      end
      @(negedge clk);
      rst = 1'b0;

      run_seq(1'b0, 4'b0000, 1'b0, "and");
      run_seq(1'b0, 4'b1000, 1'b0, "stuck0");
      run_seq(1'b0, 4'b0111, 1'b0, "stuck1");
      run_seq(1'b0, 4'b0000, 1'b0, "restart_ok");
      run_seq(1'b1, 4'b1111, 1'b0, "nand8");
      run_seq(1'b0, 4'b0000, 1'b1, "start_held");

      // Asynchronous reset partway through a run with a NAND gate
      sel   = 1'b0;
      flip1 = 4'b1111;
      @(negedge clk);
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      repeat (17) @(posedge clk);
      #3;
      check("midrst:err_before", 32'(o_err), 32'd1);
      rst = 1'b1;
      #1;
      check("midrst:ab",   32'({o_a, o_b}), 32'd0);
      check("midrst:busy", 32'(o_busy), 32'd0);
      check("midrst:done", 32'(o_done), 32'd0);
      check("midrst:err",  32'(o_err),  32'd0);
      check("midrst:fs",   32'(o_fs),   32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_seq(1'b0, 4'b0000, 1'b0, "post_rst");

      for (int i = 0; i < 6; i++)
         run_seq(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), "rand");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/and_gate_vector_sequencer.md
Name: and_gate_vector_sequencer

Overview:
- Synthesizable stimulus-and-check stage that wraps a 2-input AND gate under test.
- Drives the gate inputs a/b through the fixed sequence 00, 01, 11, 10.
- Holds each vector for HOLD_CYCLES clocks, samples the gate output, and compares it against the expected AND result.
- Reports a saturating error count, the first failing vector, and a pass/done summary. This replaces the timed, non-synthesizable stimulus loop with a clocked, on-chip self-test.

Parameters:
- HOLD_CYCLES, 10, clocks each vector is held before its output is sampled; legal range >= 2.
- PASSES, 1, number of full 4-vector sweeps per run; legal range >= 1.
- ERR_W, 4, width of the error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  run request; sampled only in IDLE and DONE.
- gate_out  input  1  output of the AND gate under test.
- a  output  1  gate input a (registered).
- b  output  1  gate input b (registered).
- busy  output  1  high while a run is in progress.
- done  output  1  high in DONE; held until next start or reset.
- pass  output  1  done && (err_count == 0).
- err_count  output  ERR_W  mismatches in the current or last run; saturates at 2^ERR_W-1.
- fail_seen  output  1  at least one mismatch in the current or last run.
- first_fail  output  2  {a,b} of the first mismatching vector; valid when fail_seen=1.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high (rst).
- Reset values (rst=1, asynchronous): state=IDLE, a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_seen=0, first_fail=2'b00. Hold counter, vector index and pass counter all =0.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on a clk edge with start=1:
  - a,b=00 from that edge; busy=1.
  - err_count, fail_seen and first_fail are cleared on the same edge.
- RUN:
  - hold_cnt counts 0..HOLD_CYCLES-1 per vector.
  - On the edge where hold_cnt==HOLD_CYCLES-1, gate_out is compared with (a & b).
  - On mismatch: err_count increments unless already at 2^ERR_W-1. If fail_seen==0, first_fail<={a,b} and fail_seen<=1.
  - On that same edge, the vector advances 00->01->11->10. After 10 it wraps to 00 and pass_cnt increments.
- RUN -> DONE on the compare edge of vector 10 in the last pass:
  - busy=0, done=1, a,b return to 00.
  - The final compare result is included in err_count.
- Run length: busy is high for exactly 4*PASSES*HOLD_CYCLES cycles. done rises on the edge that ends the last hold window.
- DONE -> RUN on start=1:
  - Same actions as IDLE->RUN; done drops on that edge.
  - Results stay stable in DONE until restart.
- start=1 while in RUN is ignored; there is no restart or abort mid-run.
- gate_out is sampled only on compare edges; gate_out values at other times have no effect.
- Reset asserted mid-RUN: immediate return to the reset values. No done pulse; no results retained.
- pass is combinational from done and err_count==0.
- All other outputs are registered.

Test Plan:
- Correct AND, HOLD_CYCLES=10, PASSES=1:
  - pulse start -> a/b = 00, 01, 11, 10, each for 10 cycles.
  - done rises 40 cycles after the start edge.
  - err_count=0, fail_seen=0, pass=1.
- gate_out stuck at 0 -> err_count=1, first_fail=2'b11, pass=0.
- gate_out stuck at 1 -> err_count=3, first_fail=2'b00, pass=0.
- Inverted gate (NAND), PASSES=8, ERR_W=4:
  - 32 raw mismatches -> err_count saturates at 15.
  - first_fail=2'b00; done at 320 cycles after start.
- Reset mid-run:
  - assert rst at cycle 17 of a run -> a=b=0, busy=0, done=0, err_count=0 immediately, without waiting for a clk edge.
  - start after release -> full 40-cycle run.
- Start handling:
  - start held high throughout RUN -> run length still 40 cycles, no restart.
  - start in DONE after a failing run -> err_count/fail_seen cleared on that edge; a correct gate then gives pass=1.
